captura_jogada: RTL
===================

Name: captura_jogada

Overview:
- Upstream input stage of the play-comparison datapath, between the raw `chaves` switches/buttons and the comparator/control unit of the game circuit.
- Synchronizes and debounces the 4-bit one-hot key input.
- Emits exactly one `jogada_feita` pulse per valid press, and holds the pressed key in a register for the comparator.
- Rejects multi-key presses and keys that are still held over from earlier; a release is required between plays.

Parameters:
- DEBOUNCE_CYCLES, 2, consecutive clock cycles the synchronized input must stay constant before it is accepted (≥1). FPGA build overrides to 500000.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- chaves  in  4  raw asynchronous key inputs; one-hot when valid.
- habilita  in  1  from the control unit; a play may be accepted only while high.
- limpa  in  1  synchronous clear of `jogada`.
- jogada  out  4  last accepted one-hot key; held until the next accepted play or `limpa`.
- jogada_feita  out  1  one-cycle pulse when a valid play is accepted.
- jogada_invalida  out  1  one-cycle pulse when a stable multi-key press is seen while enabled.
- db_estado  out  3  current FSM state code.

Behaviour:
- Reset (asynchronous, `reset`=0):
  - `sync1`, `sync2`, `cand` = 0000; counter = 0.
  - FSM = ESPERA_SOLTA.
  - `jogada` = 0000; `jogada_feita` = 0; `jogada_invalida` = 0; `db_estado` = 3'd0.
  - A reset mid-operation aborts any filtering; no pulse is generated.
- Synchronizer: two flops, `chaves` → `sync1` → `sync2`.
- Filter:
  - Each edge: if `sync2` ≠ `cand`, then `cand` ← `sync2` and counter ← 0.
  - Otherwise counter saturates at DEBOUNCE_CYCLES.
  - `estavel` = (counter == DEBOUNCE_CYCLES).
- FSM states:
  - ESPERA_SOLTA = 0: waits until `estavel` and `cand` = 0000, then → OCIOSO.
  - OCIOSO = 1: on `estavel` and `cand` ≠ 0000:
    - if `habilita` = 0 → ESPERA_SOLTA (a press while disabled is discarded);
    - else if `cand` is one-hot → ACEITA;
    - else → INVALIDA.
  - ACEITA = 2: `jogada_feita` = 1 for this state's single cycle; `jogada` ← `cand` on entry. Unconditional → ESPERA_SOLTA.
  - INVALIDA = 3: `jogada_invalida` = 1 for one cycle; `jogada` unchanged. Unconditional → ESPERA_SOLTA.
  - Codes 4–7 are unused; they recover to ESPERA_SOLTA.
- Outputs are registered or decoded from state only; there are no combinational paths from `chaves`.
- Latency: `chaves` changes after edge 0 and is held → `cand` settles at edge 3 → `estavel` at edge 3+DEBOUNCE_CYCLES → ACEITA entered at the next edge.
  - Default: `jogada_feita` is high during the cycle after edge 6.
- Glitch: any change of `sync2` before `estavel` restarts the count. A bounce shorter than DEBOUNCE_CYCLES never produces a pulse.
- Key held at reset, or held when `habilita` rises: no pulse until the key is released (stable 0000) and pressed again.
- Key change without release (0001 → 0010 held): no second pulse.
- `limpa`:
  - `jogada` ← 0000 at the next edge, except in a cycle where ACEITA loads (load wins).
  - FSM is unaffected.
- `habilita` dropping while in ACEITA/INVALIDA: the pulse still completes.

Decomposition:
- Shared package (`jogo_pkg`): state encodings ESPERA_SOLTA..INVALIDA (3-bit) and default DEBOUNCE_CYCLES.
- Sub-module `filtro_debounce` (synchronizer + candidate register + saturating counter; outputs `cand`, `estavel`), parameterized by DEBOUNCE_CYCLES/CNT_W.
- The top level contains the FSM and the `jogada` register.

Test Plan:
- Reset: `reset`=0 mid-simulation while 0100 is held → all outputs 0, `db_estado`=0; after release → `db_estado`=1 with no pulse.
- Clean press: `habilita`=1, `chaves`=0010 after edge 0, held 8 cycles → `jogada_feita` high only in the cycle after edge 6; `jogada`=0010; a 0001 press later gives `jogada`=0001.
- Bounce: 0100 for 1 cycle, 0000 for 1, then 0100 held → exactly one pulse, timed from the last change; `jogada`=0100.
- Multi-key: 0011 held → `jogada_invalida` pulse only, `jogada` keeps its old value; after release, 1000 → `jogada_feita`, `jogada`=1000.
- Disabled/held: `habilita`=0, press 0001 held, raise `habilita` → no pulse; release, press 0001 again → one pulse.
- `limpa` and no-release change: 0001 → 0010 without an intervening 0000 → one pulse only; `limpa`=1 → `jogada`=0000 next edge.

Source files
------------

// File: rtl/jogo_pkg.sv
// Shared definitions for the play-capture datapath: FSM state codes, the default
// debounce length and a one-hot helper.
package jogo_pkg;

   typedef enum logic [2:0] {
      ESPERA_SOLTA = 3'd0,
      OCIOSO       = 3'd1,
      ACEITA       = 3'd2,
      INVALIDA     = 3'd3
   } estado_t;

   localparam int DEBOUNCE_CYCLES_PADRAO = 2;

   // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
   function automatic logic one_hot4(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
   endfunction

endpackage

// File: rtl/filtro_debounce.sv
// Two-flop synchronizer followed by a candidate register and a saturating counter;
// estavel means the candidate has been seen unchanged for DEBOUNCE_CYCLES edges.
module filtro_debounce
   import jogo_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_PADRAO,
   parameter int CNT_W           = 20
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] chaves,
   output logic [3:0] cand,
   output logic       estavel
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   logic [3:0]       sync1_reg;
   logic [3:0]       sync2_reg;
   logic [3:0]       cand_reg;
   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_reg <= 4'b0000;
         sync2_reg <= 4'b0000;
         cand_reg  <= 4'b0000;
         cnt_reg   <= '0;
      end else begin
         sync1_reg <= chaves;
         sync2_reg <= sync1_reg;
         // Any change restarts the stability count from zero.
         if (sync2_reg != cand_reg) begin
            cand_reg <= sync2_reg;
            cnt_reg  <= '0;
         end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   assign cand    = cand_reg;
   assign estavel = (cnt_reg == CNT_MAX);

endmodule

// File: rtl/captura_jogada.sv
// Play capture: debounced key input feeding an accept/reject FSM that pulses once per
// valid press and holds the accepted one-hot key for the comparator.
module captura_jogada
   import jogo_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_PADRAO,
   parameter int CNT_W           = 20
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] chaves,
   input  logic       habilita,
   input  logic       limpa,
   output logic [3:0] jogada,
   output logic       jogada_feita,
   output logic       jogada_invalida,
   output logic [2:0] db_estado
);

   logic [3:0] cand;
   logic       estavel;
   estado_t    state_reg;
   estado_t    state_next;
   logic       carrega;
   logic [3:0] jogada_reg;

   filtro_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_filtro (
      .clock  (clock),
      .reset  (reset),
      .chaves (chaves),
      .cand   (cand),
      .estavel(estavel)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg <= ESPERA_SOLTA;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      carrega    = 1'b0;
      case (state_reg)
         ESPERA_SOLTA: begin
            if (estavel && (cand == 4'b0000)) state_next = OCIOSO;
         end
         OCIOSO: begin
            // A stable press while disabled is swallowed; a release is needed to re-arm.
            if (estavel && (cand != 4'b0000)) begin
               if (!habilita) begin
                  state_next = ESPERA_SOLTA;
               end else if (one_hot4(cand)) begin
                  state_next = ACEITA;
                  carrega    = 1'b1;
               end else begin
                  state_next = INVALIDA;
               end
            end
         end
         ACEITA:   state_next = ESPERA_SOLTA;
         INVALIDA: state_next = ESPERA_SOLTA;
         default:  state_next = ESPERA_SOLTA;
      endcase
   end

   // Loading a new play takes priority over a clear in the same cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         jogada_reg <= 4'b0000;
      end else if (carrega) begin
         jogada_reg <= cand;
      end else if (limpa) begin
         jogada_reg <= 4'b0000;
      end
   end

   assign jogada          = jogada_reg;
   assign jogada_feita    = (state_reg == ACEITA);
   assign jogada_invalida = (state_reg == INVALIDA);
   assign db_estado       = state_reg;

endmodule
